// File: rtl/bist_controller.sv
// BIST sequencer: drives a maximal-length 4-bit LFSR pattern stream into the
// CUT, clears the downstream MISR before each run, then captures the final
// signature and compares it against a golden value.
module bist_controller #(
  parameter logic [3:0] SEED         = 4'b0001,
  parameter int         NUM_PATTERNS = 15,
  parameter logic [3:0] GOLDEN_SIG   = 4'b0000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] signature,
  output logic [3:0] pattern,
  output logic       pattern_valid,
  output logic       test_mode,
  output logic       misr_clear,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] sig_captured
);

  // An all-zero seed would lock the LFSR, so it is replaced by 0001.
  localparam logic [3:0] SEED_N = (SEED == 4'b0000) ? 4'b0001 : SEED;
  localparam logic [7:0] LAST   = 8'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {IDLE, INIT, RUN, COMPARE, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] count, count_next;
  logic [3:0] pattern_next, sig_captured_next;
  logic       pattern_valid_next, test_mode_next, misr_clear_next;
  logic       busy_next, done_next, pass_next;

  // x^4 + x^3 + 1, period 15.
  function automatic logic [3:0] lfsr_step(input logic [3:0] p);
    return {p[2:0], p[3] ^ p[2]};
  endfunction

  // Next-state and next-output decode; every output is registered from here.
  always_comb begin
    state_next         = state;
    count_next         = count;
    pattern_next       = pattern;
    pattern_valid_next = pattern_valid;
    test_mode_next     = test_mode;
    misr_clear_next    = misr_clear;
    done_next          = done;
    pass_next          = pass;
    sig_captured_next  = sig_captured;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next      = INIT;
          pattern_next    = SEED_N;
          test_mode_next  = 1'b1;
          misr_clear_next = 1'b1;
          done_next       = 1'b0;
          pass_next       = 1'b0;
        end
      end
      INIT: begin
        state_next         = RUN;
        misr_clear_next    = 1'b0;
        pattern_valid_next = 1'b1;
        count_next         = 8'd0;
      end
      RUN: begin
        pattern_next = lfsr_step(pattern);
        count_next   = count + 8'd1;
        if (count == LAST) begin
          state_next         = COMPARE;
          pattern_valid_next = 1'b0;
        end
      end
      COMPARE: begin
        state_next        = DONE;
        sig_captured_next = signature;
        pass_next         = (signature == GOLDEN_SIG);
        done_next         = 1'b1;
        test_mode_next    = 1'b0;
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over everything an active run would otherwise do, including
    // the COMPARE capture; the last captured signature is kept.
    if (abort && (state == INIT || state == RUN || state == COMPARE)) begin
      state_next         = IDLE;
      pattern_next       = SEED_N;
      pattern_valid_next = 1'b0;
      test_mode_next     = 1'b0;
      misr_clear_next    = 1'b0;
      done_next          = 1'b0;
      pass_next          = 1'b0;
      sig_captured_next  = sig_captured;
    end

    busy_next = (state_next == INIT) || (state_next == RUN) || (state_next == COMPARE);
  end

  // State and output registers with asynchronous reset to the idle values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 8'd0;
      pattern       <= SEED_N;
      pattern_valid <= 1'b0;
      test_mode     <= 1'b0;
      misr_clear    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      sig_captured  <= 4'd0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      pattern       <= pattern_next;
      pattern_valid <= pattern_valid_next;
      test_mode     <= test_mode_next;
      misr_clear    <= misr_clear_next;
      busy          <= busy_next;
      done          <= done_next;
      pass          <= pass_next;
      sig_captured  <= sig_captured_next;
    end
  end

endmodule
